muldiv_unit: RTL

Iterative multiply/divide unit with architectural HI/LO result registers, parametrised in operand width. It sits beside the single-cycle ALU in the execute stage and handles MULT/MULTU/DIV/DIVU plus MTHI/MTLO. It uses a start/busy/done handshake so hazard logic can stall on `busy` and flush an in-flight operation with `cancel`. Latency is fixed (WIDTH+1 cycles), replacing a combinational multiplier.

---
 rtl/muldiv_pkg.sv | 21 ++
 rtl/muldiv_unit_cond_negate.sv | 12 +
 rtl/muldiv_unit.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared op codes and FSM state encoding for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  function automatic logic is_muldiv(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

endpackage

// File: rtl/muldiv_unit_cond_negate.sv
// Conditional two's-complement negation: y = neg ? -x : x.
module cond_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x,
  input  logic             neg,
  output logic [WIDTH-1:0] y
);

  assign y = neg ? (~x + WIDTH'(1)) : x;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers and start/busy/done handshake.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     opnd;
  logic                 is_div;
  logic                 neg_res;
  logic                 neg_rem;
  logic                 div0;

  logic                 op_signed;
  logic                 accept;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       rem_sh;
  logic                 rem_ge;
  logic [WIDTH-1:0]     rem_sub;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  // Divide by zero leaves an all-ones quotient regardless of operand signs.
  function automatic logic [WIDTH-1:0] quot_sat(input logic zero_div,
                                               input logic [WIDTH-1:0] q);
    return zero_div ? '1 : q;
  endfunction

  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign accept    = (state == ST_IDLE) && start && !cancel;

  cond_negate #(.WIDTH(WIDTH)) u_mag_a (
    .x(a), .neg(op_signed & a[WIDTH-1]), .y(a_mag));
  cond_negate #(.WIDTH(WIDTH)) u_mag_b (
    .x(b), .neg(op_signed & b[WIDTH-1]), .y(b_mag));

  // Shift-add: add multiplicand into the upper half when the current LSB is set.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Restoring divide: shift partial remainder left, subtract divisor if it fits.
  assign rem_sh   = acc[2*WIDTH-1:WIDTH-1];
  assign rem_ge   = (rem_sh >= {1'b0, opnd});
  assign rem_sub  = WIDTH'(rem_sh - {1'b0, opnd});
  assign div_next = rem_ge ? {rem_sub, acc[WIDTH-2:0], 1'b1}
                           : {acc[2*WIDTH-2:0], 1'b0};

  cond_negate #(.WIDTH(2*WIDTH)) u_fix_prod (
    .x(acc), .neg(neg_res), .y(prod_fix));
  cond_negate #(.WIDTH(WIDTH)) u_fix_quo (
    .x(acc[WIDTH-1:0]), .neg(neg_res), .y(quo_fix));
  cond_negate #(.WIDTH(WIDTH)) u_fix_rem (
    .x(acc[2*WIDTH-1:WIDTH]), .neg(neg_rem), .y(rem_fix));

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (accept && is_muldiv(op)) state_n = ST_RUN;
      ST_RUN:  if (cancel) state_n = ST_IDLE;
               else if (cnt == CNT_LAST) state_n = ST_FIX;
      ST_FIX:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n != ST_IDLE);
      done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_muldiv(op)) begin
              acc     <= {{WIDTH{1'b0}}, a_mag};
              opnd    <= b_mag;
              cnt     <= '0;
              is_div  <= op[1];
              neg_res <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_rem <= op_signed & a[WIDTH-1];
              div0    <= (b == '0);
            end else if (op == OP_MTHI) begin
              hi <= a;
            end else if (op == OP_MTLO) begin
              lo <= a;
            end
          end
        end
        // RUN: one radix-2 step per edge
        ST_RUN: begin
          if (!cancel) begin
            acc <= is_div ? div_next : mul_next;
            cnt <= cnt + CNT_W'(1);
          end
        end
        // FIX: sign correction and architectural writeback
        ST_FIX: begin
          if (!cancel) begin
            if (is_div) begin
              hi <= rem_fix;
              lo <= quot_sat(div0, quo_fix);
            end else begin
              {hi, lo} <= prod_fix;
            end
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
